mem_arbiter: RTL

- Shares the single-port unified instruction/data memory of the multi-cycle CPU between two requesters: the CPU memory interface (instruction fetch, lw, sw) and the DMA/loader port.
- Serialises accesses, owns the memory-side handshake and read-latency timing, and returns a one-cycle ready pulse to the winning requester.
- The CPU controller holds its current FSM state while its request is pending, so arbitration loss shows up at the CPU as extra wait cycles.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 56 +++++
 rtl/arb_pick.sv | 48 ++++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the unified-memory arbiter.
//                Holds the arbiter FSM state encoding and the owner codes
//                that appear on the owner output.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DMA  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bus bundle for the unified-memory arbiter: CPU requester
//                port, DMA requester port, memory-side port and owner status.
//                slave  : arbiter view (requests and mem_rdata in).
//                master : environment view (requesters and memory model).
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  owner
    );
endinterface
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pick
//  Description : Grant selection between CPU and DMA with starvation guard.
//                CPU wins ties unless DMA has lost STARVE_LIMIT ties in a
//                row, in which case DMA wins the next tie.
//  Ports       : clk, reset        clock, async active-high reset
//                decide            high while the arbiter is in IDLE
//                cpu_req, dma_req  pending requests
//                grant_cpu/_dma    one-hot grant, valid only while decide=1
//  Revision    : 1.0  initial release
// ============================================================================
module arb_pick #(
    parameter int STARVE_LIMIT = 3
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic decide,
    input  wire logic cpu_req,
    input  wire logic dma_req,
    output logic      grant_cpu,
    output logic      grant_dma
);
    localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve;
    logic       w_tie;
    logic       w_dma_first;

    always_comb begin
        w_tie       = cpu_req & dma_req;
        w_dma_first = (r_starve == c_LIMIT);
        grant_cpu   = decide & cpu_req & ~(dma_req & w_dma_first);
        grant_dma   = decide & dma_req & ~(cpu_req & ~w_dma_first);
    end

    // Counts consecutive tie losses by DMA; any DMA grant resets it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (grant_dma) begin
            r_starve <= '0;
        end else if (decide && w_tie && (r_starve != c_LIMIT)) begin
            r_starve <= r_starve + 4'd1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Serialises CPU and DMA accesses onto a single-port memory.
//                IDLE samples requests and captures the winner's attributes,
//                ISSUE strobes the memory for one cycle, WAIT covers the read
//                latency, RESP pulses ready to the owner for one cycle.
//  Ports       : clk, reset  clock, async active-high reset
//                bus         mem_arbiter_if.slave (CPU, DMA, memory, owner)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_arbiter_if.slave  bus
);
    localparam logic [2:0] c_LAT = 3'(MEM_LAT);

    arb_state_t        r_state;
    logic              r_we;
    logic [2:0]        r_lat;

    logic              w_decide;
    logic              w_grant_cpu;
    logic              w_grant_dma;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_decide = (r_state == IDLE);

    arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk       (clk),
        .reset     (reset),
        .decide    (w_decide),
        .cpu_req   (bus.cpu_req),
        .dma_req   (bus.dma_req),
        .grant_cpu (w_grant_cpu),
        .grant_dma (w_grant_dma)
    );

    always_comb begin
        w_sel_we    = w_grant_dma ? bus.dma_we    : bus.cpu_we;
        w_sel_addr  = w_grant_dma ? bus.dma_addr  : bus.cpu_addr;
        w_sel_wdata = w_grant_dma ? bus.dma_wdata : bus.cpu_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_we          <= 1'b0;
            r_lat         <= '0;
            bus.owner     <= OWN_NONE;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_ready <= 1'b0;
            bus.dma_ready <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.dma_rdata <= '0;
        end else begin
            // Ready is a single-cycle pulse; only the edge into RESP sets it.
            bus.cpu_ready <= 1'b0;
            bus.dma_ready <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_grant_cpu || w_grant_dma) begin
                        // Attributes are frozen here; the mem_* registers
                        // double as the capture registers for the access.
                        r_state       <= ISSUE;
                        r_we          <= w_sel_we;
                        bus.owner     <= w_grant_dma ? OWN_DMA : OWN_CPU;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= w_sel_we;
                        bus.mem_addr  <= w_sel_addr;
                        bus.mem_wdata <= w_sel_wdata;
                    end
                end
                ISSUE: begin
                    bus.mem_en    <= 1'b0;
                    bus.mem_we    <= 1'b0;
                    bus.mem_addr  <= '0;
                    bus.mem_wdata <= '0;
                    if (r_we) begin
                        r_state       <= RESP;
                        bus.cpu_ready <= (bus.owner == OWN_CPU);
                        bus.dma_ready <= (bus.owner == OWN_DMA);
                    end else begin
                        r_state <= WAIT;
                        r_lat   <= c_LAT;
                    end
                end
                WAIT: begin
                    r_lat <= r_lat - 3'd1;
                    // Counter reaching 1 marks the cycle mem_rdata is valid.
                    if (r_lat == 3'd1) begin
                        r_state <= RESP;
                        if (bus.owner == OWN_DMA) begin
                            bus.dma_rdata <= bus.mem_rdata;
                            bus.dma_ready <= 1'b1;
                        end else begin
                            bus.cpu_rdata <= bus.mem_rdata;
                            bus.cpu_ready <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_state   <= IDLE;
                    bus.owner <= OWN_NONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
